// File: rtl/adder_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_stim_pkg
// Description : Shared types, constants and helpers for the AXI-Stream adder
//               traffic generator/checker (FSM states, LFSR taps and seeds,
//               sum width).
// Revision    : 1.0 - initial release
// ============================================================================
package adder_stim_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [31:0] LFSR32_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR32_SEED_DEFAULT = 32'hACE1_0001;

  // 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (backpressure source)
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [15:0] LFSR16_SEED = 16'hBEEF;

  // Sum of two WIDTH-bit operands needs one extra bit for the carry
  function automatic int sum_width(input int width);
    return width + 1;
  endfunction

  function automatic logic [31:0] lfsr32_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR32_TAPS) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR16_TAPS) : (v >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_stim_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_stim_fifo
// Description : Small synchronous FIFO holding expected sums. Supports a
//               clear that may coincide with a push (the pushed word becomes
//               the only entry) and simultaneous push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_stim_fifo
  import adder_stim_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   w_wr_base;
  logic              w_full, w_empty, w_push;

  // Extra pointer MSB distinguishes full from empty
  assign w_full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_wr_base = clear_i ? '0 : wr_ptr_q;
  assign w_push    = push_i && (clear_i || !w_full);

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign head_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Next pointer values: clear wins over pop, push lands after a clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (pop_i && !w_empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (w_push) begin
      wr_ptr_d = w_wr_base + PTR_ONE;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_push) begin
        mem_q[w_wr_base[ADDR_W-1:0]] <= push_data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_adder_stimulus.sv
`default_nettype none
// ============================================================================
// Module      : axis_adder_stimulus
// Description : Traffic generator and checker for an AXI-Stream two-operand
//               adder. Issues LFSR-derived operand pairs on data1/data2,
//               queues the expected sums, and checks the returned sum stream.
//               Optional macro ADDER_STIM_BACKPRESSURE_EN adds a 16-bit LFSR
//               that randomly throttles pair issue and sum acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_adder_stimulus
  import adder_stim_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          TRANS_NUMBER = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] SEED         = 32'hACE1_0001
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start_i,
  output logic [WIDTH-1:0]     data1_o_tdata,
  output logic                 data1_o_tvalid,
  input  logic                 data1_o_tready,
  output logic [WIDTH-1:0]     data2_o_tdata,
  output logic                 data2_o_tvalid,
  input  logic                 data2_o_tready,
  input  logic [WIDTH:0]       sum_i_tdata,
  input  logic                 sum_i_tvalid,
  output logic                 sum_i_tready,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [15:0]          err_cnt_o,
  output logic [15:0]          trans_cnt_o
);

  localparam int          SUM_W       = sum_width(WIDTH);
  localparam logic [15:0] TRANS_TOTAL = 16'(TRANS_NUMBER);
  localparam logic [15:0] TRANS_LAST  = 16'(TRANS_NUMBER - 1);

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   d1_data_q, d1_data_d, d2_data_q, d2_data_d;
  logic               d1_valid_q, d1_valid_d, d2_valid_q, d2_valid_d;
  logic [15:0]        issued_q, issued_d, trans_q, trans_d, err_q, err_d;

  logic               w_start, w_active, w_issue, w_last_issue;
  logic               w_full, w_empty, w_sum_ready, w_sum_hs;
  logic               w_bp_ready, w_bp_issue;
  logic [15:0]        w_issued_base;
  logic [WIDTH-1:0]   w_op1, w_op2;
  logic [SUM_W-1:0]   w_expected, w_head;

`ifdef ADDER_STIM_BACKPRESSURE_EN
  logic [15:0] bp_lfsr_q;

  // Free-running throttle source while a run is in progress
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      bp_lfsr_q <= LFSR16_SEED;
    end else if (w_active) begin
      bp_lfsr_q <= lfsr16_step(bp_lfsr_q);
    end
  end

  assign w_bp_ready = bp_lfsr_q[0];
  assign w_bp_issue = bp_lfsr_q[1];
`else
  assign w_bp_ready = 1'b1;
  assign w_bp_issue = 1'b1;
`endif

  // Operands come from the LFSR value before it steps
  assign w_op1      = lfsr_q[WIDTH-1:0];
  assign w_op2      = lfsr_q[31:32-WIDTH];
  assign w_expected = SUM_W'(w_op1) + SUM_W'(w_op2);

  // A start in IDLE/DONE may already issue the first pair in the same cycle,
  // so the first tvalid appears one cycle after start_i
  assign w_start       = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign w_active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign w_issue       = (w_start || (state_q == ST_RUN && !w_full)) &&
                         !d1_valid_q && !d2_valid_q && w_bp_issue;
  assign w_issued_base = w_start ? 16'd0 : issued_q;
  assign w_last_issue  = w_issue && (w_issued_base == TRANS_LAST);

  assign w_sum_ready = !w_empty && w_active && w_bp_ready;
  assign w_sum_hs    = sum_i_tvalid && w_sum_ready;

  axis_stim_fifo #(
    .DATA_W (SUM_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clear_i     (w_start),
    .push_i      (w_issue),
    .push_data_i (w_expected),
    .pop_i       (w_sum_hs),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head)
  );

  // Run sequencing: IDLE/DONE -> RUN -> DRAIN -> DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = w_last_issue ? ST_DRAIN : ST_RUN;
      ST_RUN:           if (w_last_issue) state_d = ST_DRAIN;
      ST_DRAIN:         if (trans_q == TRANS_TOTAL) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Channel, LFSR and counter next-state logic
  always_comb begin
    d1_valid_d = d1_valid_q && !data1_o_tready;
    d2_valid_d = d2_valid_q && !data2_o_tready;
    d1_data_d  = d1_data_q;
    d2_data_d  = d2_data_q;
    lfsr_d     = lfsr_q;
    issued_d   = w_issued_base;
    trans_d    = w_start ? 16'd0 : trans_q;
    err_d      = w_start ? 16'd0 : err_q;
    if (w_issue) begin
      d1_valid_d = 1'b1;
      d2_valid_d = 1'b1;
      d1_data_d  = w_op1;
      d2_data_d  = w_op2;
      lfsr_d     = lfsr32_step(lfsr_q);
      issued_d   = w_issued_base + 16'd1;
    end
    if (w_sum_hs) begin
      trans_d = trans_q + 16'd1;
      if ((sum_i_tdata != w_head) && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'd1;
      end
    end
  end

  // State registers, asynchronously cleared by the active-high reset
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      d1_data_q  <= '0;
      d2_data_q  <= '0;
      d1_valid_q <= 1'b0;
      d2_valid_q <= 1'b0;
      issued_q   <= '0;
      trans_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      d1_data_q  <= d1_data_d;
      d2_data_q  <= d2_data_d;
      d1_valid_q <= d1_valid_d;
      d2_valid_q <= d2_valid_d;
      issued_q   <= issued_d;
      trans_q    <= trans_d;
      err_q      <= err_d;
    end
  end

  assign data1_o_tdata  = d1_data_q;
  assign data1_o_tvalid = d1_valid_q;
  assign data2_o_tdata  = d2_data_q;
  assign data2_o_tvalid = d2_valid_q;
  assign sum_i_tready   = w_sum_ready;
  assign busy_o         = w_active;
  assign done_o         = (state_q == ST_DONE);
  assign pass_o         = (state_q == ST_DONE) && (err_q == 16'd0);
  assign err_cnt_o      = err_q;
  assign trans_cnt_o    = trans_q;

endmodule
`default_nettype wire

// File: doc/axis_adder_stimulus.md
Name: axis_adder_stimulus

Overview:
Hardware traffic generator and checker for the AXI-Stream two-operand adder.
- Acts as AXI-Stream master on both operand streams (data1, data2) and as slave on the sum stream.
- Generates pseudorandom operand pairs and stores the expected sums in an internal FIFO.
- Compares each returned sum against the FIFO head and reports pass/fail.
- Used for on-chip self-test and for bench loopback against the adder.

Parameters:
- WIDTH, 8: operand width in bits; legal range 1..16.
- TRANS_NUMBER, 16: operand pairs per test run; range 1..65535.
- FIFO_DEPTH, 4: expected-sum FIFO depth; power of 2, at least 2.
- SEED, 32'hACE1_0001: LFSR reload value; must be non-zero.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-high
- start_i  in  1  single-cycle pulse; starts a run
- data1_o_tdata  out  WIDTH  operand 1
- data1_o_tvalid  out  1
- data1_o_tready  in  1
- data2_o_tdata  out  WIDTH  operand 2
- data2_o_tvalid  out  1
- data2_o_tready  in  1
- sum_i_tdata  in  WIDTH+1  sum returned by the adder
- sum_i_tvalid  in  1
- sum_i_tready  out  1
- busy_o  out  1  high in RUN or DRAIN
- done_o  out  1  high in DONE
- pass_o  out  1  valid while done_o is high
- err_cnt_o  out  16  mismatch count; saturates at 16'hFFFF
- trans_cnt_o  out  16  sums checked

Behaviour:
- Reset: asserting aresetn=1 forces, asynchronously:
  - all tvalid low, sum_i_tready low, tdata zero;
  - FSM to IDLE; FIFO empty; counters zero;
  - LFSR reloaded with SEED;
  - busy_o, done_o and pass_o low.
  Reset mid-run abandons the run. No state survives reset.
- LFSR: 32-bit Galois, taps 32,22,2,1. Steps exactly once per issued pair.
- Operand mapping: data1 = lfsr[WIDTH-1:0]; data2 = lfsr[31:32-WIDTH]. Both taken from the LFSR value before the step.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start_i go to RUN; clear counters and FIFO.
  - DONE: on start_i go to RUN; clear counters and FIFO. The LFSR is not reloaded, so a new run produces new data.
  - RUN: go to DRAIN in the cycle after the TRANS_NUMBER-th pair is issued.
  - DRAIN: go to DONE when trans_cnt reaches TRANS_NUMBER.
  - start_i is ignored in RUN and DRAIN.
- Pair issue (RUN only):
  - A pair is issued when both channels are idle (tvalid low) and the FIFO is not full.
  - Issue sets both tvalid high in the same cycle, loads both tdata, and pushes the expected sum (zero-extended data1 + data2, WIDTH+1 bits) into the FIFO.
- Channel handshake rules:
  - Each channel holds tdata and tvalid stable until its own tvalid&&tready handshake, then drops tvalid the next cycle.
  - The two channels complete independently.
  - The next pair is issued no earlier than the cycle after both channels are idle, so each channel has at least one idle cycle between transfers.
- Sum path:
  - sum_i_tready = FIFO not empty, in RUN or DRAIN.
  - On a sum handshake: pop the FIFO head; if sum_i_tdata differs from it, increment err_cnt; always increment trans_cnt.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - A sum with tvalid high while the FIFO is empty is not accepted (tready low). It is never counted.
- Results: pass_o = (err_cnt == 0) while in DONE; low otherwise.
- Latency: first tvalid rises one cycle after the start_i cycle.

Optional Feature:
- Macro: ADDER_STIM_BACKPRESSURE_EN.
- Defined:
  - A second 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hBEEF) steps every cycle while in RUN or DRAIN.
  - sum_i_tready is additionally gated by its bit 0.
  - Pair issue is additionally gated by its bit 1.
  - Exercises adder stalls in both directions.
- Undefined: no second LFSR; tready and issue are ungated as specified above.
- Functional results (pass_o, counts) are identical either way.

Decomposition:
- Package adder_stim_pkg holds:
  - FSM state enum;
  - LFSR tap constants and default seeds;
  - sum width function (WIDTH+1).
- One sub-module, axis_stim_fifo: synchronous FIFO with WIDTH+1 data bits and DEPTH entries, exposing full, empty, push, pop and head outputs.

Test Plan:
- Ideal adder model, all treadys high, TRANS_NUMBER=16 -> done_o high, pass_o=1, err_cnt_o=0, trans_cnt_o=16; operand values match a software LFSR model started from SEED.
- Model returns sum+1 on the 3rd result only -> err_cnt_o=1, pass_o=0, trans_cnt_o=16.
- data1_o_tready low for 20 cycles, data2_o_tready high -> data1 tdata and tvalid stable for 20 cycles; exactly one data2 handshake; no new pair issued until data1 handshakes.
- Sums never returned, FIFO_DEPTH=4 -> exactly 4 pairs issued; then both tvalids stay low and sum_i_tready=1; after 4 correct sums the run continues to DONE.
- aresetn pulsed after 5 pairs, then start_i -> all outputs return to reset values immediately; first pair after restart equals the first pair of the original run.
- Model truncates sums to WIDTH bits; run until a pair with a carry occurs (e.g. 0xC8+0x64=0x12C) -> err_cnt_o increments for each carry pair only.
